// File: rtl/sr_ff_bank.sv
// sr_ff_bank: synchronous bank of WIDTH flip-flops with a run-time mode
// (SR / JK / D / T) shared by all channels. In SR mode, the parameter
// SR_POLICY decides the result of s=r=1. An s=r=1 combination is also
// flagged, counted (saturating) and latched in a sticky bit.
// Optional feature macro: FF_BANK_EDGE_DETECT_EN adds the registered
// per-channel rise/fall outputs.
module sr_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b0}},
  parameter int               SR_POLICY = 0,
  parameter int               CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qp,
  output logic             illegal,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
`ifdef FF_BANK_EDGE_DETECT_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [1:0] POL_HOLD  = 2'd0;
  localparam logic [1:0] POL_SET   = 2'd1;
  localparam logic [1:0] POL_RESET = 2'd2;
  localparam logic [1:0] POLICY    = SR_POLICY[1:0];

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sticky_q, err_sticky_d;
  logic             illegal_s;
  logic [CNT_W-1:0] cnt_base_s;
  logic             sticky_base_s;

  // An s=r=1 on any channel counts as a single illegal event for the cycle.
  assign illegal_s = en & (mode == MODE_SR) & (|(a & b));

  // Channel next-state: decode the shared mode per bit; en=0 holds everything.
  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        MODE_SR: begin
          for (int i = 0; i < WIDTH; i++) begin
            case ({a[i], b[i]})
              2'b10: q_d[i] = 1'b1;
              2'b01: q_d[i] = 1'b0;
              2'b11: begin
                case (POLICY)
                  POL_SET:   q_d[i] = 1'b1;
                  POL_RESET: q_d[i] = 1'b0;
                  POL_HOLD:  q_d[i] = q_q[i];
                  default:   q_d[i] = q_q[i];
                endcase
              end
              default: q_d[i] = q_q[i];
            endcase
          end
        end
        MODE_JK: begin
          for (int i = 0; i < WIDTH; i++) begin
            case ({a[i], b[i]})
              2'b10:   q_d[i] = 1'b1;
              2'b01:   q_d[i] = 1'b0;
              2'b11:   q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
        end
        MODE_D:  q_d = a;
        MODE_T:  q_d = q_q ^ a;
        default: q_d = q_q;
      endcase
    end else begin
      q_d = q_q;
    end
  end

  // Error bookkeeping: the clear is applied first so a same-cycle event lands on zero.
  always_comb begin
    cnt_base_s    = err_cnt_q;
    sticky_base_s = err_sticky_q;
    err_cnt_d     = err_cnt_q;
    err_sticky_d  = err_sticky_q;
    illegal_d     = illegal_s;
    if (clr_err) begin
      cnt_base_s    = {CNT_W{1'b0}};
      sticky_base_s = 1'b0;
    end else begin
      cnt_base_s    = err_cnt_q;
      sticky_base_s = err_sticky_q;
    end
    if (illegal_s) begin
      err_cnt_d    = (cnt_base_s == CNT_MAX) ? CNT_MAX : (cnt_base_s + CNT_ONE);
      err_sticky_d = 1'b1;
    end else begin
      err_cnt_d    = cnt_base_s;
      err_sticky_d = sticky_base_s;
    end
  end

  // State and status registers with synchronous reset that overrides all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q          <= INIT;
      illegal_q    <= 1'b0;
      err_cnt_q    <= {CNT_W{1'b0}};
      err_sticky_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      illegal_q    <= illegal_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

`ifdef FF_BANK_EDGE_DETECT_EN
  logic [WIDTH-1:0] rise_q, fall_q;

  // Edge flags compare the old and new q so they line up with the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= {WIDTH{1'b0}};
      fall_q <= {WIDTH{1'b0}};
    end else begin
      rise_q <= q_d & ~q_q;
      fall_q <= ~q_d & q_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

  assign q          = q_q;
  assign qp         = ~q_q;
  assign illegal    = illegal_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed, table-driven bench for sr_ff_bank (INIT=8'hA5, SR_POLICY=0, CNT_W=4).
module tb_sr_ff_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       clr_err;
  logic [7:0] q;
  logic [7:0] qp;
  logic       illegal;
  logic [3:0] err_cnt;
  logic       err_sticky;
`ifdef FF_BANK_EDGE_DETECT_EN
  logic [7:0] rise;
  logic [7:0] fall;
`endif

  int n_checks;
  int n_errors;

  sr_ff_bank #(
    .WIDTH    (8),
    .INIT     (8'hA5),
    .SR_POLICY(0),
    .CNT_W    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .clr_err   (clr_err),
    .q         (q),
    .qp        (qp),
    .illegal   (illegal),
    .err_cnt   (err_cnt),
    .err_sticky(err_sticky)
`ifdef FF_BANK_EDGE_DETECT_EN
    ,
    .rise      (rise),
    .fall      (fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr;
    logic [7:0] eq;
    logic       eill;
    logic [3:0] ecnt;
    logic       est;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic [1:0] m,
                     input logic [7:0] va, input logic [7:0] vb, input logic c,
                     input logic [7:0] eq, input logic eill, input logic [3:0] ecnt,
                     input logic est);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.a = va; v.b = vb; v.clr = c;
    v.eq = eq; v.eill = eill; v.ecnt = ecnt; v.est = est;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic [7:0] va, input logic [7:0] vb, input logic c);
    rst = r; en = e; mode = m; a = va; b = vb; clr_err = c;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);

    //   rst  en    mode   a      b      clr    q      ill   cnt    sticky
    add(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0,  8'hA5, 1'b0, 4'd0, 1'b0); // reset
    add(1'b0, 1'b0, 2'b00, 8'hFF, 8'hFF, 1'b0,  8'hA5, 1'b0, 4'd0, 1'b0); // en=0 hold
    add(1'b0, 1'b0, 2'b00, 8'hFF, 8'hFF, 1'b0,  8'hA5, 1'b0, 4'd0, 1'b0);
    add(1'b0, 1'b0, 2'b00, 8'hFF, 8'hFF, 1'b0,  8'hA5, 1'b0, 4'd0, 1'b0);
    add(1'b0, 1'b1, 2'b00, 8'h0F, 8'hF0, 1'b0,  8'h0F, 1'b0, 4'd0, 1'b0); // SR set/reset
    add(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0,  8'h0F, 1'b0, 4'd0, 1'b0); // SR hold
    add(1'b0, 1'b1, 2'b00, 8'h01, 8'h01, 1'b0,  8'h0F, 1'b1, 4'd1, 1'b1); // SR 11 hold
    add(1'b0, 1'b0, 2'b00, 8'h01, 8'h01, 1'b0,  8'h0F, 1'b0, 4'd1, 1'b1); // en=0: no count
    add(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1,  8'h0F, 1'b0, 4'd0, 1'b0); // clr while en=0
    add(1'b0, 1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0,  8'hF0, 1'b0, 4'd0, 1'b0); // JK toggle
    add(1'b0, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b0,  8'hFF, 1'b0, 4'd0, 1'b0); // JK set
    add(1'b0, 1'b1, 2'b01, 8'h00, 8'h0F, 1'b0,  8'hF0, 1'b0, 4'd0, 1'b0); // JK reset low
    add(1'b0, 1'b1, 2'b10, 8'h3C, 8'hFF, 1'b0,  8'h3C, 1'b0, 4'd0, 1'b0); // D, b ignored
    add(1'b0, 1'b0, 2'b10, 8'hC3, 8'h00, 1'b0,  8'h3C, 1'b0, 4'd0, 1'b0); // D held
    add(1'b0, 1'b1, 2'b11, 8'h81, 8'hFF, 1'b0,  8'hBD, 1'b0, 4'd0, 1'b0); // T
    add(1'b0, 1'b1, 2'b11, 8'h01, 8'h00, 1'b0,  8'hBC, 1'b0, 4'd0, 1'b0); // T q[0]
    add(1'b0, 1'b1, 2'b00, 8'h01, 8'h03, 1'b0,  8'hBC, 1'b1, 4'd1, 1'b1); // mixed SR
    add(1'b0, 1'b1, 2'b00, 8'h01, 8'h01, 1'b1,  8'hBC, 1'b1, 4'd1, 1'b1); // clr + illegal
    add(1'b1, 1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0,  8'hA5, 1'b0, 4'd0, 1'b0); // reset override
    add(1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 1'b0,  8'h00, 1'b0, 4'd0, 1'b0); // D to 00
    add(1'b0, 1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0,  8'hFF, 1'b0, 4'd0, 1'b0); // JK FF,00,FF
    add(1'b0, 1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0,  8'h00, 1'b0, 4'd0, 1'b0);
    add(1'b0, 1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0,  8'hFF, 1'b0, 4'd0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].en, vq[i].mode, vq[i].a, vq[i].b, vq[i].clr);
      step();
      check($sformatf("vec%0d q", i), {24'd0, q}, {24'd0, vq[i].eq});
      check($sformatf("vec%0d qp", i), {24'd0, qp}, {24'd0, ~vq[i].eq});
      check($sformatf("vec%0d illegal", i), {31'd0, illegal}, {31'd0, vq[i].eill});
      check($sformatf("vec%0d err_cnt", i), {28'd0, err_cnt}, {28'd0, vq[i].ecnt});
      check($sformatf("vec%0d err_sticky", i), {31'd0, err_sticky}, {31'd0, vq[i].est});
    end

    // Saturation: 20 illegal cycles from err_cnt=0, q=FF under hold policy.
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, 2'b00, 8'h01, 8'h01, 1'b0);
      step();
      check($sformatf("sat%0d q", k), {24'd0, q}, 32'h0000_00FF);
      check($sformatf("sat%0d illegal", k), {31'd0, illegal}, 32'd1);
      check($sformatf("sat%0d err_cnt", k), {28'd0, err_cnt}, (k < 15) ? (k + 1) : 15);
      check($sformatf("sat%0d sticky", k), {31'd0, err_sticky}, 32'd1);
    end
    drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    step();
    check("satclr err_cnt", {28'd0, err_cnt}, 32'd0);
    check("satclr sticky", {31'd0, err_sticky}, 32'd0);
    check("satclr illegal", {31'd0, illegal}, 32'd0);

    // Edge detection in D mode: FF -> 00 -> 81 -> 01 -> 01.
    drive(1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 1'b0);
    step();
    check("edge0 q", {24'd0, q}, 32'h00);
`ifdef FF_BANK_EDGE_DETECT_EN
    check("edge0 rise", {24'd0, rise}, 32'h00);
    check("edge0 fall", {24'd0, fall}, 32'hFF);
`endif
    drive(1'b0, 1'b1, 2'b10, 8'h81, 8'h00, 1'b0);
    step();
    check("edge1 q", {24'd0, q}, 32'h81);
`ifdef FF_BANK_EDGE_DETECT_EN
    check("edge1 rise", {24'd0, rise}, 32'h81);
    check("edge1 fall", {24'd0, fall}, 32'h00);
`endif
    drive(1'b0, 1'b1, 2'b10, 8'h01, 8'h00, 1'b0);
    step();
    check("edge2 q", {24'd0, q}, 32'h01);
`ifdef FF_BANK_EDGE_DETECT_EN
    check("edge2 rise", {24'd0, rise}, 32'h00);
    check("edge2 fall", {24'd0, fall}, 32'h80);
`endif
    step();
    check("edge3 q", {24'd0, q}, 32'h01);
`ifdef FF_BANK_EDGE_DETECT_EN
    check("edge3 rise", {24'd0, rise}, 32'h00);
    check("edge3 fall", {24'd0, fall}, 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
